// File: rtl/status_register.sv
`default_nettype none
// ============================================================================
// Module      : status_register
// Description : 6502 processor status (P) register. Holds N, V, D, I, Z, C;
//               applies ALU flag updates, set/clear instructions, PLP/RTI
//               pulls and BIT loads; builds the pushed P byte; detects NMI
//               falling edges and masks IRQ with a boundary-delayed I copy.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   core clock, rising edge
//   reset          in   asynchronous active-high reset
//   alu_n/v/z/c    in   ALU flag results
//   nzcv_we[3:0]   in   per-flag ALU write enable {N,Z,C,V}
//   flag_op[2:0]   in   0 none,1 CLC,2 SEC,3 CLI,4 SEI,5 CLD,6 SED,7 CLV
//   bit_load       in   BIT: N<-p_din[7], V<-p_din[6], Z<-alu_z
//   p_load         in   PLP/RTI: all flags from p_din
//   p_din[7:0]     in   pulled byte / BIT operand
//   brk_push       in   B bit value placed in p_out
//   int_ack        in   interrupt sequence entered (sets I, clears NMI)
//   instr_boundary in   opcode-fetch strobe, samples I into the IRQ mask
//   irq_n          in   level IRQ, active low
//   nmi_n          in   edge NMI, active low
//   p_out[7:0]     out  {N,V,1,B,D,I,Z,C}
//   carry_out      out  C flag
//   overflow_out   out  V flag
//   decimal_out    out  D flag
//   irq_pending    out  IRQ requested and not masked
//   nmi_pending    out  latched NMI request
// ============================================================================
module status_register (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic [3:0] nzcv_we,
    input  logic [2:0] flag_op,
    input  logic       bit_load,
    input  logic       p_load,
    input  logic [7:0] p_din,
    input  logic       brk_push,
    input  logic       int_ack,
    input  logic       instr_boundary,
    input  logic       irq_n,
    input  logic       nmi_n,
    output logic [7:0] p_out,
    output logic       carry_out,
    output logic       overflow_out,
    output logic       decimal_out,
    output logic       irq_pending,
    output logic       nmi_pending
);

    localparam logic [2:0] c_OP_NONE = 3'd0;
    localparam logic [2:0] c_OP_CLC  = 3'd1;
    localparam logic [2:0] c_OP_SEC  = 3'd2;
    localparam logic [2:0] c_OP_CLI  = 3'd3;
    localparam logic [2:0] c_OP_SEI  = 3'd4;
    localparam logic [2:0] c_OP_CLD  = 3'd5;
    localparam logic [2:0] c_OP_SED  = 3'd6;
    localparam logic [2:0] c_OP_CLV  = 3'd7;

    // nzcv_we bit positions
    localparam int c_WE_N = 3;
    localparam int c_WE_Z = 2;
    localparam int c_WE_C = 1;
    localparam int c_WE_V = 0;

    logic r_n, r_v, r_d, r_i, r_z, r_c;
    logic w_n_nxt, w_v_nxt, w_d_nxt, w_i_nxt, w_z_nxt, w_c_nxt;
    logic r_i_poll;
    logic r_nmi_sync;
    logic r_nmi_prev;
    logic r_nmi_pending;
    logic w_nmi_edge;

    // ------------------------------------------------------------------------
    // Per-flag next state. Each flag resolves its own priority chain so a
    // source that does not target a flag leaves lower-priority sources free
    // to update it (e.g. CLC alongside an ALU N/Z write).
    // ------------------------------------------------------------------------
    always_comb begin
        w_n_nxt = r_n;
        w_v_nxt = r_v;
        w_d_nxt = r_d;
        w_i_nxt = r_i;
        w_z_nxt = r_z;
        w_c_nxt = r_c;

        // N
        if (p_load)                w_n_nxt = p_din[7];
        else if (bit_load)         w_n_nxt = p_din[7];
        else if (nzcv_we[c_WE_N])  w_n_nxt = alu_n;

        // V
        if (p_load)                w_v_nxt = p_din[6];
        else if (flag_op == c_OP_CLV) w_v_nxt = 1'b0;
        else if (bit_load)         w_v_nxt = p_din[6];
        else if (nzcv_we[c_WE_V])  w_v_nxt = alu_v;

        // D
        if (p_load)                   w_d_nxt = p_din[3];
        else if (flag_op == c_OP_CLD) w_d_nxt = 1'b0;
        else if (flag_op == c_OP_SED) w_d_nxt = 1'b1;

        // I: interrupt entry masks further IRQs regardless of other sources
        if (int_ack)                  w_i_nxt = 1'b1;
        else if (p_load)              w_i_nxt = p_din[2];
        else if (flag_op == c_OP_CLI) w_i_nxt = 1'b0;
        else if (flag_op == c_OP_SEI) w_i_nxt = 1'b1;

        // Z
        if (p_load)                w_z_nxt = p_din[1];
        else if (bit_load)         w_z_nxt = alu_z;
        else if (nzcv_we[c_WE_Z])  w_z_nxt = alu_z;

        // C
        if (p_load)                   w_c_nxt = p_din[0];
        else if (flag_op == c_OP_CLC) w_c_nxt = 1'b0;
        else if (flag_op == c_OP_SEC) w_c_nxt = 1'b1;
        else if (nzcv_we[c_WE_C])     w_c_nxt = alu_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n <= 1'b0;
            r_v <= 1'b0;
            r_d <= 1'b0;
            r_i <= 1'b1;
            r_z <= 1'b0;
            r_c <= 1'b0;
        end else begin
            r_n <= w_n_nxt;
            r_v <= w_v_nxt;
            r_d <= w_d_nxt;
            r_i <= w_i_nxt;
            r_z <= w_z_nxt;
            r_c <= w_c_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // IRQ mask copy. Sampling the pre-update I only at opcode fetch makes
    // CLI/SEI/PLP take effect one instruction late, as on the real part.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i_poll <= 1'b1;
        end else if (instr_boundary) begin
            r_i_poll <= r_i;
        end
    end

    // ------------------------------------------------------------------------
    // NMI edge detect. nmi_n is first captured in r_nmi_sync, then compared
    // with the previous sample, so a fall shows on nmi_pending two edges
    // later. Both stages reset to 1: if nmi_n is held low through reset
    // release, the first low samples count as a fall and exactly one NMI
    // fires after reset. This is intentional.
    // A new edge coinciding with int_ack wins, so that request is not lost.
    // ------------------------------------------------------------------------
    assign w_nmi_edge = r_nmi_prev & ~r_nmi_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nmi_sync    <= 1'b1;
            r_nmi_prev    <= 1'b1;
            r_nmi_pending <= 1'b0;
        end else begin
            r_nmi_sync <= nmi_n;
            r_nmi_prev <= r_nmi_sync;
            if (w_nmi_edge) begin
                r_nmi_pending <= 1'b1;
            end else if (int_ack) begin
                r_nmi_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign p_out        = {r_n, r_v, 1'b1, brk_push, r_d, r_i, r_z, r_c};
    assign carry_out    = r_c;
    assign overflow_out = r_v;
    assign decimal_out  = r_d;
    assign irq_pending  = ~irq_n & ~r_i_poll;
    assign nmi_pending  = r_nmi_pending;

endmodule
`default_nettype wire

// File: tb/tb_status_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_status_register
// Description : Directed self-checking bench for status_register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_status_register;

    logic       clk;
    logic       reset;
    logic       alu_n, alu_v, alu_z, alu_c;
    logic [3:0] nzcv_we;
    logic [2:0] flag_op;
    logic       bit_load;
    logic       p_load;
    logic [7:0] p_din;
    logic       brk_push;
    logic       int_ack;
    logic       instr_boundary;
    logic       irq_n;
    logic       nmi_n;
    logic [7:0] p_out;
    logic       carry_out, overflow_out, decimal_out;
    logic       irq_pending, nmi_pending;

    int n_checks = 0;
    int n_errors = 0;

    status_register dut (
        .clk            (clk),
        .reset          (reset),
        .alu_n          (alu_n),
        .alu_v          (alu_v),
        .alu_z          (alu_z),
        .alu_c          (alu_c),
        .nzcv_we        (nzcv_we),
        .flag_op        (flag_op),
        .bit_load       (bit_load),
        .p_load         (p_load),
        .p_din          (p_din),
        .brk_push       (brk_push),
        .int_ack        (int_ack),
        .instr_boundary (instr_boundary),
        .irq_n          (irq_n),
        .nmi_n          (nmi_n),
        .p_out          (p_out),
        .carry_out      (carry_out),
        .overflow_out   (overflow_out),
        .decimal_out    (decimal_out),
        .irq_pending    (irq_pending),
        .nmi_pending    (nmi_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_n = 0; alu_v = 0; alu_z = 0; alu_c = 0;
        nzcv_we = 4'h0; flag_op = 3'd0; bit_load = 0; p_load = 0;
        p_din = 8'h00; int_ack = 0; instr_boundary = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        brk_push = 1; irq_n = 0; nmi_n = 1;
        reset = 1;
        #1;
        n_checks++;
        if (p_out !== 8'h34) begin
            n_errors++; $display("FAIL reset_p_out: got %h expected %h", p_out, 8'h34);
        end
        n_checks++;
        if (irq_pending !== 1'b0) begin
            n_errors++; $display("FAIL reset_irq_pending: got %b expected 0", irq_pending);
        end
        n_checks++;
        if ({carry_out, overflow_out, decimal_out, nmi_pending} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_outputs: got %b expected 0000",
                                 {carry_out, overflow_out, decimal_out, nmi_pending});
        end
        tick();
        tick();
        reset = 0;
        brk_push = 0;
        irq_n = 1;
        #1;
        n_checks++;
        if (p_out !== 8'h24) begin
            n_errors++; $display("FAIL reset_p_out_b0: got %h expected %h", p_out, 8'h24);
        end
    endtask

    task automatic test_p_load_and_clc();
        p_load = 1; p_din = 8'hFF;
        #1;
        n_checks++;   // no combinational path from load inputs to p_out
        if (p_out !== 8'h24) begin
            n_errors++; $display("FAIL pload_comb_path: got %h expected %h", p_out, 8'h24);
        end
        tick();
        idle_inputs();
        n_checks++;
        if (p_out !== 8'hEF) begin
            n_errors++; $display("FAIL pload_ff: got %h expected %h", p_out, 8'hEF);
        end
        // CLC with full ALU write: C<-0 from CLC, N,Z,V from ALU (all 0)
        flag_op = 3'd1; nzcv_we = 4'hF; alu_c = 1; alu_n = 0; alu_z = 0; alu_v = 0;
        tick();
        idle_inputs();
        n_checks++;
        if (p_out !== 8'h2C) begin
            n_errors++; $display("FAIL clc_with_alu: got %h expected %h", p_out, 8'h2C);
        end
        n_checks++;
        if ({carry_out, overflow_out, decimal_out} !== 3'b001) begin
            n_errors++; $display("FAIL clc_outputs: got %b expected 001",
                                 {carry_out, overflow_out, decimal_out});
        end
    endtask

    task automatic test_irq_mask();
        irq_n = 0;
        flag_op = 3'd3;   // CLI
        tick();
        idle_inputs();
        n_checks++;
        if (p_out[2] !== 1'b0) begin
            n_errors++; $display("FAIL cli_i_flag: got %b expected 0", p_out[2]);
        end
        n_checks++;
        if (irq_pending !== 1'b0) begin
            n_errors++; $display("FAIL cli_irq_delayed: got %b expected 0", irq_pending);
        end
        tick();
        n_checks++;
        if (irq_pending !== 1'b0) begin
            n_errors++; $display("FAIL cli_irq_no_boundary: got %b expected 0", irq_pending);
        end
        instr_boundary = 1;
        tick();
        instr_boundary = 0;
        n_checks++;
        if (irq_pending !== 1'b1) begin
            n_errors++; $display("FAIL cli_irq_after_boundary: got %b expected 1", irq_pending);
        end
        irq_n = 1;
        #1;
        n_checks++;
        if (irq_pending !== 1'b0) begin
            n_errors++; $display("FAIL irq_deassert: got %b expected 0", irq_pending);
        end
        irq_n = 0;
        flag_op = 3'd4;   // SEI
        tick();
        idle_inputs();
        n_checks++;
        if (irq_pending !== 1'b1) begin
            n_errors++; $display("FAIL sei_irq_delayed: got %b expected 1", irq_pending);
        end
        instr_boundary = 1;
        tick();
        instr_boundary = 0;
        n_checks++;
        if (irq_pending !== 1'b0) begin
            n_errors++; $display("FAIL sei_irq_after_boundary: got %b expected 0", irq_pending);
        end
        irq_n = 1;
    endtask

    task automatic test_nmi();
        nmi_n = 0;
        tick();
        n_checks++;
        if (nmi_pending !== 1'b0) begin
            n_errors++; $display("FAIL nmi_one_edge: got %b expected 0", nmi_pending);
        end
        tick();
        n_checks++;
        if (nmi_pending !== 1'b1) begin
            n_errors++; $display("FAIL nmi_two_edges: got %b expected 1", nmi_pending);
        end
        int_ack = 1;
        tick();
        int_ack = 0;
        n_checks++;
        if (nmi_pending !== 1'b0) begin
            n_errors++; $display("FAIL nmi_ack_clear: got %b expected 0", nmi_pending);
        end
        for (int k = 0; k < 8; k++) tick();
        n_checks++;
        if (nmi_pending !== 1'b0) begin
            n_errors++; $display("FAIL nmi_held_low: got %b expected 0", nmi_pending);
        end
        nmi_n = 1;
        tick(); tick();
        nmi_n = 0;
        tick(); tick();
        n_checks++;
        if (nmi_pending !== 1'b1) begin
            n_errors++; $display("FAIL nmi_retrigger: got %b expected 1", nmi_pending);
        end
    endtask

    task automatic test_back_to_back();
        // nmi_pending is set from the previous task; produce a fresh edge
        nmi_n = 1;
        tick(); tick();
        nmi_n = 0;
        tick();            // fall captured; detection happens on next edge
        int_ack = 1;
        tick();
        int_ack = 0;
        n_checks++;
        if (nmi_pending !== 1'b1) begin
            n_errors++; $display("FAIL nmi_edge_vs_ack: got %b expected 1", nmi_pending);
        end
        int_ack = 1;
        tick();
        int_ack = 0;
        n_checks++;
        if (nmi_pending !== 1'b0) begin
            n_errors++; $display("FAIL nmi_second_ack: got %b expected 0", nmi_pending);
        end
        nmi_n = 1;
        // load all flags set except I
        p_load = 1; p_din = 8'hFB;
        tick();
        idle_inputs();
        n_checks++;
        if (p_out !== 8'hEB) begin
            n_errors++; $display("FAIL pload_fb: got %h expected %h", p_out, 8'hEB);
        end
        int_ack = 1; p_load = 1; p_din = 8'h00;
        tick();
        idle_inputs();
        n_checks++;
        if (p_out !== 8'h24) begin
            n_errors++; $display("FAIL ack_vs_pload: got %h expected %h", p_out, 8'h24);
        end
    endtask

    task automatic test_bit_load();
        bit_load = 1; p_din = 8'hC0;
        alu_z = 1; alu_c = 1; alu_n = 0; alu_v = 0; nzcv_we = 4'hF;
        tick();
        idle_inputs();
        n_checks++;
        if (p_out !== 8'hE7) begin
            n_errors++; $display("FAIL bit_load: got %h expected %h", p_out, 8'hE7);
        end
        n_checks++;
        if ({carry_out, overflow_out} !== 2'b11) begin
            n_errors++; $display("FAIL bit_load_cv: got %b expected 11", {carry_out, overflow_out});
        end
    endtask

    task automatic test_flag_ops();
        // sequence starting from p_out = E7
        logic [2:0] ops [6]  = '{3'd7, 3'd6, 3'd1, 3'd5, 3'd2, 3'd0};
        logic [3:0] wes [6]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b1001};
        logic [7:0] exps [6] = '{8'hA7, 8'hAF, 8'hAE, 8'hA6, 8'hA7, 8'h67};
        for (int k = 0; k < 6; k++) begin
            flag_op = ops[k];
            nzcv_we = wes[k];
            alu_n = 0; alu_v = 1; alu_z = 0; alu_c = 0;
            tick();
            idle_inputs();
            n_checks++;
            if (p_out !== exps[k]) begin
                n_errors++; $display("FAIL flag_op_step%0d: got %h expected %h", k, p_out, exps[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        nmi_n = 0;
        tick(); tick();
        #2;
        reset = 1;
        #1;
        n_checks++;
        if ({p_out, nmi_pending} !== {8'h24, 1'b0}) begin
            n_errors++; $display("FAIL async_reset: got %h/%b expected 24/0", p_out, nmi_pending);
        end
        tick();
        reset = 0;
        // nmi_n still low: exactly one NMI fires after reset
        tick(); tick();
        n_checks++;
        if (nmi_pending !== 1'b1) begin
            n_errors++; $display("FAIL nmi_after_reset: got %b expected 1", nmi_pending);
        end
    endtask

    initial begin
        test_reset();
        test_p_load_and_clc();
        test_irq_mask();
        test_nmi();
        test_back_to_back();
        test_bit_load();
        test_flag_ops();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
